// File: rtl/bidir_bus_sequencer.sv
// Arbitrates one shared bidirectional pad bus between a write and a read requester,
// generating setup/strobe/hold timing with an enforced idle turnaround after every transaction.
module bidir_bus_sequencer #(
  parameter int WIDTH     = 16,
  parameter int SETUP_CYC = 1,
  parameter int STB_CYC   = 2,
  parameter int HOLD_CYC  = 1,
  parameter int TURN_CYC  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ack,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic [WIDTH-1:0] pad_out,
  output logic             pad_oe,
  input  logic [WIDTH-1:0] pad_in,
  output logic             bus_stb,
  output logic             bus_rnw
);

  localparam int CW = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_SETUP = 3'd1,
    WR_STB   = 3'd2,
    WR_HOLD  = 3'd3,
    RD_STB   = 3'd4,
    TURN     = 3'd5
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            prio_rd_reg;
  logic            grant_wr, grant_rd, sample_rd;

  logic             wr_ack_reg, rd_ack_reg, rd_valid_reg, busy_reg;
  logic             pad_oe_reg, bus_stb_reg, bus_rnw_reg;
  logic [WIDTH-1:0] pad_out_reg, rd_data_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    sample_rd  = 1'b0;
    case (state_reg)
      IDLE: begin
        // When both requests are pending, prio_rd_reg picks the type not granted last
        if (wr_req && (!rd_req || !prio_rd_reg)) begin
          grant_wr   = 1'b1;
          state_next = WR_SETUP;
          cnt_next   = CW'(SETUP_CYC - 1);
        end else if (rd_req) begin
          grant_rd   = 1'b1;
          state_next = RD_STB;
          cnt_next   = CW'(STB_CYC - 1);
        end
      end
      WR_SETUP: begin
        if (cnt_reg == '0) begin
          state_next = WR_STB;
          cnt_next   = CW'(STB_CYC - 1);
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      WR_STB: begin
        if (cnt_reg == '0) begin
          state_next = WR_HOLD;
          cnt_next   = CW'(HOLD_CYC - 1);
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      WR_HOLD: begin
        if (cnt_reg == '0) begin
          state_next = TURN;
          cnt_next   = CW'(TURN_CYC - 1);
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      RD_STB: begin
        if (cnt_reg == '0) begin
          sample_rd  = 1'b1;
          state_next = TURN;
          cnt_next   = CW'(TURN_CYC - 1);
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      TURN: begin
        if (cnt_reg == '0) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      prio_rd_reg  <= 1'b0;
      wr_ack_reg   <= 1'b0;
      rd_ack_reg   <= 1'b0;
      rd_valid_reg <= 1'b0;
      busy_reg     <= 1'b0;
      pad_oe_reg   <= 1'b0;
      bus_stb_reg  <= 1'b0;
      bus_rnw_reg  <= 1'b0;
      pad_out_reg  <= '0;
      rd_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      wr_ack_reg   <= grant_wr;
      rd_ack_reg   <= grant_rd;
      rd_valid_reg <= sample_rd;
      // Outputs are decoded from the next state so they line up with the state register
      busy_reg     <= (state_next != IDLE);
      pad_oe_reg   <= (state_next == WR_SETUP) || (state_next == WR_STB) ||
                      (state_next == WR_HOLD);
      bus_stb_reg  <= (state_next == WR_STB) || (state_next == RD_STB);
      if (grant_wr) begin
        pad_out_reg <= wr_data;
        bus_rnw_reg <= 1'b0;
        prio_rd_reg <= 1'b1;
      end
      if (grant_rd) begin
        bus_rnw_reg <= 1'b1;
        prio_rd_reg <= 1'b0;
      end
      if (sample_rd) begin
        rd_data_reg <= pad_in;
      end
    end
  end

  assign wr_ack   = wr_ack_reg;
  assign rd_ack   = rd_ack_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_data_reg;
  assign busy     = busy_reg;
  assign pad_oe   = pad_oe_reg;
  assign pad_out  = pad_out_reg;
  assign bus_stb  = bus_stb_reg;
  assign bus_rnw  = bus_rnw_reg;

endmodule

// File: tb/tb_bidir_bus_sequencer.sv
// Directed bench for bidir_bus_sequencer: write/read timing, round-robin order,
// turnaround gap, mid-transaction reset and withdrawn requests.
module tb_bidir_bus_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req, rd_req;
  logic [15:0] wr_data, pad_in;
  logic        wr_ack, rd_ack, rd_valid, busy, pad_oe, bus_stb, bus_rnw;
  logic [15:0] rd_data, pad_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bidir_bus_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .wr_req  (wr_req),
    .wr_data (wr_data),
    .wr_ack  (wr_ack),
    .rd_req  (rd_req),
    .rd_ack  (rd_ack),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .busy    (busy),
    .pad_out (pad_out),
    .pad_oe  (pad_oe),
    .pad_in  (pad_in),
    .bus_stb (bus_stb),
    .bus_rnw (bus_rnw)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_w [7];
    logic [4:0] exp_r [5];
    logic [1:0] ord_exp [4];
    logic [1:0] ord [4];
    int n, gap, cyc;
    logic seen_rd, prev_oe, prev_wr_ack, prev_rd_ack, any_bad;

    exp_w = '{4'b1101, 4'b0111, 4'b0111, 4'b0101, 4'b0001, 4'b0001, 4'b0000};
    exp_r = '{5'b10011, 5'b00011, 5'b01001, 5'b00001, 5'b00000};
    ord_exp = '{2'd0, 2'd1, 2'd0, 2'd1};

    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; wr_data = '0; pad_in = '0;
    tick(); tick();
    chk("reset_ctrl", {wr_ack, rd_ack, rd_valid, busy, pad_oe, bus_stb, bus_rnw}, 0);
    chk("reset_data", {pad_out, rd_data}, 0);
    rst = 1'b0;
    tick();

    // 1: single write
    wr_req = 1'b1; wr_data = 16'hA5C3;
    tick();
    wr_req = 1'b0; wr_data = 16'h0000;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("wr_timing_c%0d", i + 1), {wr_ack, pad_oe, bus_stb, busy}, exp_w[i]);
      if (pad_oe) chk($sformatf("wr_pad_out_c%0d", i + 1), pad_out, 16'hA5C3);
      if (i < 4) chk($sformatf("wr_rnw_c%0d", i + 1), bus_rnw, 0);
      if (i < 6) tick();
    end

    // 2: single read
    rd_req = 1'b1; pad_in = 16'h1234;
    tick();
    rd_req = 1'b0;
    chk("rd_rnw", bus_rnw, 1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rd_timing_c%0d", i + 1), {rd_ack, rd_valid, pad_oe, bus_stb, busy}, exp_r[i]);
      if (i == 2) begin
        chk("rd_data", rd_data, 16'h1234);
        pad_in = 16'hFFFF;
      end
      if (i < 4) tick();
    end
    chk("rd_data_held", rd_data, 16'h1234);
    chk("rnw_kept_after_read", bus_rnw, 1);

    // 3/4: both requests held -> W,R,W,R with turnaround gap before write after read
    wr_req = 1'b1; rd_req = 1'b1; wr_data = 16'h5A5A;
    n = 0; gap = 0; seen_rd = 1'b0; prev_oe = 1'b0; prev_wr_ack = 1'b0; prev_rd_ack = 1'b0;
    cyc = 0;
    while (cyc < 80 && !(n >= 4 && !busy && !rd_valid)) begin
      tick();
      cyc++;
      if (wr_ack || rd_ack) begin
        chk("ack_single_cycle", {(wr_ack && prev_wr_ack), (rd_ack && prev_rd_ack)}, 0);
        if (n < 4) ord[n] = wr_ack ? 2'd0 : 2'd1;
        n++;
        if (n == 4) begin
          wr_req = 1'b0; rd_req = 1'b0;
        end
      end
      if (bus_stb && bus_rnw) begin
        gap = 0; seen_rd = 1'b1;
      end else if (!pad_oe) begin
        gap++;
      end
      if (pad_oe && !prev_oe && seen_rd) chk("turn_gap_ge3", (gap >= 3), 1);
      if (pad_oe) chk("oe_not_during_rd_stb", (bus_stb && bus_rnw), 0);
      prev_oe = pad_oe; prev_wr_ack = wr_ack; prev_rd_ack = rd_ack;
    end
    chk("rr_ack_count", n, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_order_%0d", i), ord[i], ord_exp[i]);

    // 5: reset during WR_STB, then during RD_STB
    tick();
    wr_req = 1'b1; wr_data = 16'hBEEF;
    tick();
    wr_req = 1'b0;
    tick();
    chk("pre_rst_wr_stb", {pad_oe, bus_stb}, 2'b11);
    rst = 1'b1;
    tick();
    chk("rst_in_wr", {pad_oe, bus_stb, busy, wr_ack}, 0);
    rst = 1'b0;
    rd_req = 1'b1; pad_in = 16'hCAFE;
    tick();
    rd_req = 1'b0;
    tick();
    chk("pre_rst_rd_stb", {bus_stb, bus_rnw}, 2'b11);
    rst = 1'b1;
    tick();
    chk("rst_in_rd", {pad_oe, bus_stb, busy, rd_valid}, 0);
    rst = 1'b0;
    tick();
    chk("no_rd_valid_after_rst", rd_valid, 0);
    chk("rd_data_after_rst", rd_data, 0);
    wr_req = 1'b1; rd_req = 1'b1; wr_data = 16'h0F0F;
    tick();
    wr_req = 1'b0; rd_req = 1'b0;
    chk("post_rst_write_first", {wr_ack, rd_ack, pad_oe}, 3'b101);
    tick();
    chk("post_rst_wr_stb", {pad_oe, bus_stb, pad_out}, {2'b11, 16'h0F0F});
    for (int i = 0; i < 6; i++) tick();
    chk("post_rst_idle", busy, 0);

    // 6: write request withdrawn while a read is busy
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    any_bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (wr_ack || pad_oe) any_bad = 1'b1;
      tick();
    end
    chk("withdrawn_write", any_bad, 0);
    chk("withdrawn_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
